// File: rtl/regfile_pkg.sv
// Shared constants and types for the integer register file and its busy scoreboard.
// Default sizes match RV32I: 32 registers of 32 bits.
package regfile_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;

   localparam int REG_ZERO = 0;
   localparam int REG_RA   = 1;
   localparam int REG_SP   = 2;
   localparam int REG_GP   = 3;
   localparam int REG_TP   = 4;
   localparam int REG_A0   = 10;

   typedef logic [4:0]  reg_addr_t;
   typedef logic [31:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: flush beats issue, issue beats writeback clear; x0 never busy.
// Busy updates take one edge; rd_busy is combinational and masked by a same-cycle forwarded write.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NREGS  = NREGS_DEF,
   parameter int NREAD  = 2,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREAD*AW-1:0] rd_addr,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic              issue_en,
   input  logic [AW-1:0]     issue_addr,
   input  logic              flush,
   output logic [NREAD-1:0]  rd_busy
);

   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;

   always_comb begin
      busy_d = busy_q;
      for (int r = 1; r < NREGS; r++) begin
         if (flush) begin
            busy_d[r] = 1'b0;
         end else if (issue_en && (issue_addr == AW'(r))) begin
            // A new producer supersedes the one retiring this cycle.
            busy_d[r] = 1'b1;
         end else if (wr_en && (wr_addr == AW'(r))) begin
            busy_d[r] = 1'b0;
         end
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   for (genvar i = 0; i < NREAD; i++) begin : g_busy
      logic [AW-1:0] ra;
      logic          fwd;
      assign ra  = rd_addr[i*AW +: AW];
      assign fwd = (BYPASS != 0) && wr_en && (wr_addr == ra);
      assign rd_busy[i] = (ra == '0) ? 1'b0 : (fwd ? 1'b0 : busy_q[ra]);
   end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file: NREAD combinational read ports, one write port, optional write bypass, busy scoreboard.
// Reads 0 cycles, writes and busy updates land on the next rising edge; no backpressure.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int NREGS  = NREGS_DEF,
   parameter int NREAD  = 2,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREAD*AW-1:0]   rd_addr,
   output logic [NREAD*XLEN-1:0] rd_data,
   output logic [NREAD-1:0]      rd_busy,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr,
   input  logic [XLEN-1:0]       wr_data,
   input  logic                  issue_en,
   input  logic [AW-1:0]         issue_addr,
   input  logic                  flush
);

   logic [XLEN-1:0] regs_q [NREGS];
   logic [XLEN-1:0] regs_d [NREGS];

   always_comb begin
      regs_d = regs_q;
      if (wr_en && (wr_addr != '0)) begin
         regs_d[wr_addr] = wr_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < NREGS; r++) begin
            regs_q[r] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   for (genvar i = 0; i < NREAD; i++) begin : g_rd
      logic [AW-1:0] ra;
      logic          fwd;
      assign ra  = rd_addr[i*AW +: AW];
      // Reset blocks forwarding so every port reads zero while it is held.
      assign fwd = (BYPASS != 0) && !reset && wr_en && (wr_addr == ra);
      assign rd_data[i*XLEN +: XLEN] = (ra == '0) ? '0 : (fwd ? wr_data : regs_q[ra]);
   end

   regfile_scoreboard #(
      .NREGS  (NREGS),
      .NREAD  (NREAD),
      .BYPASS (BYPASS)
   ) u_scoreboard (
      .clk        (clk),
      .reset      (reset),
      .rd_addr    (rd_addr),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .issue_en   (issue_en),
      .issue_addr (issue_addr),
      .flush      (flush),
      .rd_busy    (rd_busy)
   );

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised RISC-V integer register file with N combinational read ports, one write port, optional write-to-read bypass, and a per-register busy scoreboard.
- Sits between decode and writeback in the pipelined core.
- Replaces the single-cycle, two-port negedge-write register file.
- Decode uses the busy bits to detect RAW hazards. Writeback retires results and clears the bits.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; power of two, >= 2.
- NREAD, 2, number of independent read ports, 1..4.
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports; 0 = reads return the stored value only.
- AW, $clog2(NREGS), address width; derived, not overridden.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- rd_addr  input  NREAD*AW  packed read addresses; port i = bits [i*AW +: AW].
- rd_data  output  NREAD*XLEN  packed read data, combinational.
- rd_busy  output  NREAD  busy flag for each read port's register.
- wr_en  input  1  writeback valid.
- wr_addr  input  AW  writeback destination.
- wr_data  input  XLEN  writeback value.
- issue_en  input  1  decode issued an instruction with a destination.
- issue_addr  input  AW  destination of the issued instruction.
- flush  input  1  synchronous clear of all busy bits (branch mispredict / trap).

Behaviour:
- Reset (asynchronous assert, any time, including mid-operation):
  - All NREGS registers = 0; all busy bits = 0.
  - rd_data reads 0 for every address; rd_busy = 0.
  - No initial non-zero preload.
- Register x0:
  - Reads always return 0; rd_busy for x0 is always 0.
  - Writes to x0 are ignored; issue to x0 never sets a busy bit.
- Write:
  - At posedge clk with wr_en=1 and wr_addr!=0: reg[wr_addr] <= wr_data.
  - Visible through storage one cycle after the edge.
- Read:
  - Purely combinational.
  - BYPASS=1 and wr_en=1 and wr_addr==rd_addr[i]!=0: rd_data[i] = wr_data, giving zero-latency write-then-read in the same cycle.
  - Otherwise rd_data[i] = reg[rd_addr[i]].
  - All ports are independent; identical addresses on several ports are legal.
- Busy next-state, per register r != 0, at posedge, in priority order:
  1. flush=1 -> busy[r]=0. Flush overrides issue and write in the same cycle.
  2. issue_en=1 and issue_addr==r -> busy[r]=1. Set wins over a same-cycle clear, because the new producer supersedes the retiring one.
  3. wr_en=1 and wr_addr==r -> busy[r]=0.
  4. Otherwise hold.
- rd_busy[i]:
  - Equals busy[rd_addr[i]].
  - When BYPASS=1 and a same-cycle write targets that address, rd_busy[i] is forced to 0 because the forwarded data is valid.
- Write to a non-busy register: data is stored and the busy bit stays 0. Legal, no error.
- Address width: addresses are exactly AW bits, so no out-of-range case exists.
- Latency: read 0 cycles; write-to-storage 1 edge; issue-to-busy 1 edge.

Decomposition:
- regfile_pkg holds:
  - XLEN_DEF and NREGS_DEF.
  - ABI index constants: REG_ZERO=0, REG_RA=1, REG_SP=2, REG_GP=3, REG_TP=4, REG_A0=10.
  - A typedef for the register address (logic [4:0]) and the data word (logic [31:0]) at default sizes.
- Sub-module regfile_scoreboard:
  - Contains the NREGS busy vector, the flush/issue/write priority logic, and the masked rd_busy generation.
- The top level keeps the storage array, read muxes and bypass.

Test Plan:
1. Reset, then read x0..x31 on both ports -> all rd_data=0 and rd_busy=0. Write 0xDEADBEEF to x0, read x0 -> 0.
2. Write x5=0x12345678 with rd_addr[0]=5 in the same cycle -> BYPASS=1: rd_data[0]=0x12345678 that cycle. BYPASS=0: old value 0 that cycle, 0x12345678 the next cycle.
3. Issue x7, then next cycle read x7 -> rd_busy=1. Write x7=0xA5 -> rd_busy=0 in the same cycle (BYPASS=1) and busy bit cleared after the edge.
4. Issue x9 and write x9=0x1 in the same cycle -> after the edge busy[9]=1 and reg[9]=0x1.
5. Issue x3, x4, x6 on successive cycles, then assert flush together with issue x8 -> after the edge all busy bits = 0, including x8.
6. Write x10=0xFFFF, then assert reset asynchronously mid-cycle with busy[10]=1 -> rd_data for x10 = 0 and rd_busy=0 immediately, before any clock edge.
